compute_request_arbiter: RTL and testbench
==========================================

// Module: compute_request_arbiter
// PURPOSE
//  Sits directly upstream of shared_compute_unit.
//  - Collects compute requests from all UNIT_COUNT processing units and picks one per transaction, round-robin.
//  - Registers that unit's operand and comp_type, then drives the shared unit's request/ready handshake.
//  - Captures the result on done and returns it to the winning unit with a one-cycle valid pulse.
// PARAMETERS
//  UNIT_COUNT      accel_pkg::UNIT_COUNT  number of requesting units (>=2, need not be a power of 2)
//  TIMEOUT_CYCLES  256                    WAIT-state abort limit (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk                in   1                        single clock; all logic rises on posedge
//  rst                in   1                        synchronous, active-high reset
//  unit_req           in   [UNIT_COUNT]             level request per unit; held until its result_valid
//  unit_comp_type     in   comp_type_e[UNIT_COUNT]  operation per unit
//  unit_data          in   data_t[UNIT_COUNT]       operand per unit
//  unit_grant         out  [UNIT_COUNT]             one-hot; winner, from latch through RESP
//  unit_result_valid  out  [UNIT_COUNT]             one-cycle pulse to the winner
//  unit_result        out  data_t                   shared result bus; valid with unit_result_valid
//  unit_error         out  1                        with result_valid: timeout abort (0 without macro)
//  cu_request         out  1                        request to the shared compute unit
//  cu_unit_id         out  UNIT_ID_WIDTH            id of the current winner
//  cu_comp_type       out  comp_type_e              registered operation
//  cu_data            out  data_t                   registered operand
//  cu_ready           in   1                        shared unit accepts when cu_request&&cu_ready
//  cu_done            in   1                        result valid this cycle
//  cu_result          in   data_t                   result data
//  busy               out  1                        state != IDLE
// BEHAVIOUR
//  Reset (rst high at posedge)
//  - state=IDLE, rr_ptr=0.
//  - All outputs 0; cu_comp_type=COMP_ADD.
//  - Reset mid-transaction aborts without a response; cu_request drops the next cycle.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//  - If any unit_req: winner = first set bit at or after rr_ptr, wrapping from UNIT_COUNT-1 to 0.
//  - Latch id, data and comp_type; set unit_grant[id]; go to ISSUE.
//  ISSUE
//  - cu_request=1; cu_* hold the latched values.
//  - On cu_request&&cu_ready go to WAIT and drop cu_request next cycle.
//  - cu_done seen in ISSUE, or in the handshake cycle, is ignored.
//  WAIT
//  - On cu_done capture cu_result into unit_result and go to RESP.
//  RESP
//  - unit_result_valid[id]=1 for exactly one cycle.
//  - rr_ptr = (id==UNIT_COUNT-1) ? 0 : id+1.
//  - Clear unit_grant; go to IDLE.
//  Latency and throughput
//  - Minimum: req sampled in IDLE at cycle 0 -> result_valid at cycle 3 (ready at 1, done at 2).
//  - Maximum rate is one transaction per 4 cycles.
//  Requester rules
//  - A unit deasserts unit_req in the cycle after its result_valid.
//  - A unit may deassert only after its response; early drop is a protocol error and has no defined effect.
//  - unit_req from non-winners is ignored until IDLE; it is never lost.
//  - unit_data and unit_comp_type are sampled only in IDLE.
//  Other rules
//  - Simultaneous requests: the pointer guarantees each pending unit is served within UNIT_COUNT transactions.
//  - unit_result keeps its last value between pulses.
//  - UNIT_ID_WIDTH=$clog2(UNIT_COUNT); the pointer never takes a value >= UNIT_COUNT.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined
//  - A counter runs in ISSUE+WAIT.
//  - When it reaches TIMEOUT_CYCLES: go to RESP with unit_error=1 and unit_result=0; cu_request drops.
//  - A late cu_done arriving after the abort is ignored in IDLE.
//  ARB_TIMEOUT_EN undefined
//  - No counter; the block waits indefinitely; unit_error is tied to 0.
// STRUCTURE
//  accel_pkg holds: data_t, comp_type_e, UNIT_COUNT, UNIT_ID_WIDTH, and a new arb_state_e {IDLE,ISSUE,WAIT,RESP}.
//  Sub-module rr_arbiter_pick (combinational): req vector + rr_ptr -> one-hot grant, id, any_req.
// TESTING
//  1 single: unit 2 req, ADD, data 0x0005; cu_ready@1, done@2 result 0x000A
//    -> valid[2] at cycle 3, unit_result=0x000A.
//  2 contention: units 0,1,3 request together, rr_ptr=0 -> service order 0,1,3, then 0 again if still requesting.
//  3 wrap: rr_ptr=UNIT_COUNT-1, only unit 0 requesting -> grant 0, rr_ptr becomes 1.
//  4 backpressure: cu_ready low 5 cycles, cu_done pulsed during ISSUE
//    -> cu_request held, cu_data stable, early done ignored.
//  5 reset mid-WAIT: rst at WAIT -> next cycle IDLE, all outputs 0, no result_valid, rr_ptr=0.
//  6 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: cu_done never arrives
//    -> result_valid with unit_error=1 and unit_result=0 after 8 cycles in ISSUE+WAIT.

Source files
------------

// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared types and constants for the accelerator request path: operand type,
// operation encoding, requester count, arbiter state encoding and the
// round-robin pointer advance helper.
// -----------------------------------------------------------------------------
package accel_pkg;

    localparam int UNIT_COUNT    = 4;
    localparam int UNIT_ID_WIDTH = $clog2(UNIT_COUNT);
    localparam int DATA_WIDTH    = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        COMP_ADD = 2'd0,
        COMP_SUB = 2'd1,
        COMP_MUL = 2'd2,
        COMP_MAX = 2'd3
    } comp_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Next round-robin start position: the unit after the last winner, wrapping.
    function automatic int rr_next(input int id, input int count);
        if (id == count - 1) begin
            return 0;
        end else begin
            return id + 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pick
// Combinational round-robin pick: returns the first requesting unit at or after
// the pointer, wrapping from N-1 back to 0.
// Ports:
//   i_req      [N]     request vector
//   i_ptr      [ID_W]  search start position (always < N)
//   o_grant    [N]     one-hot winner (all zero when nothing requests)
//   o_id       [ID_W]  index of the winner
//   o_any_req  1       at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_id,
    output logic            o_any_req
);

    int   w_idx;
    logic w_found;

    // Scan N positions starting at the pointer; the first set request wins.
    always_comb begin
        o_grant   = '0;
        o_id      = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        o_any_req = |i_req;
        for (int k = 0; k < N; k++) begin
            if (int'(i_ptr) + k >= N) begin
                w_idx = int'(i_ptr) + k - N;
            end else begin
                w_idx = int'(i_ptr) + k;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = ID_W'(w_idx);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/compute_request_arbiter.sv
// -----------------------------------------------------------------------------
// compute_request_arbiter
// Round-robin front end for the shared compute unit. One requester is picked
// per transaction, its operand/operation are registered and presented to the
// compute unit through a request/ready handshake, and the result is returned
// to the winner with a one-cycle valid pulse.
// Optional feature macro: ARB_TIMEOUT_EN -- aborts a transaction that stays in
// ISSUE+WAIT for TIMEOUT_CYCLES cycles, responding with unit_error=1 and a zero
// result. Without it the block waits indefinitely and unit_error stays 0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   unit_req/comp_type/data       per-unit level request, operation, operand
//   unit_grant                    one-hot winner, held from latch through RESP
//   unit_result_valid             one-cycle pulse to the winner
//   unit_result, unit_error       shared result bus and abort flag
//   cu_request/unit_id/comp_type/data  request side of the shared compute unit
//   cu_ready, cu_done, cu_result  handshake and result from the compute unit
//   busy                          transaction in progress
// -----------------------------------------------------------------------------
module compute_request_arbiter
    import accel_pkg::*;
#(
    parameter int UNIT_COUNT     = accel_pkg::UNIT_COUNT,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [UNIT_COUNT-1:0] unit_req,
    input  comp_type_e            unit_comp_type [UNIT_COUNT],
    input  data_t                 unit_data      [UNIT_COUNT],
    output logic [UNIT_COUNT-1:0] unit_grant,
    output logic [UNIT_COUNT-1:0] unit_result_valid,
    output data_t                 unit_result,
    output logic                  unit_error,
    output logic                  cu_request,
    output logic [((UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1)-1:0] cu_unit_id,
    output comp_type_e            cu_comp_type,
    output data_t                 cu_data,
    input  logic                  cu_ready,
    input  logic                  cu_done,
    input  data_t                 cu_result,
    output logic                  busy
);

    localparam int ID_W = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

    arb_state_e            r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;
    logic [UNIT_COUNT-1:0] r_grant;
    logic [UNIT_COUNT-1:0] r_result_valid;
    data_t                 r_result;
    logic                  r_error;
    logic                  r_cu_request;
    comp_type_e            r_cu_comp_type;
    data_t                 r_cu_data;
    logic                  r_busy;

    logic [UNIT_COUNT-1:0] w_pick_grant;
    logic [ID_W-1:0]       w_pick_id;
    logic                  w_any_req;
    logic                  w_timeout;

    rr_arbiter_pick #(
        .N    (UNIT_COUNT),
        .ID_W (ID_W)
    ) u_pick (
        .i_req     (unit_req),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick_grant),
        .o_id      (w_pick_id),
        .o_any_req (w_any_req)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Cycles spent in ISSUE+WAIT; cleared whenever no transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE || r_state == WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // The last allowed cycle: leave for RESP on this edge.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_id           <= '0;
            r_grant        <= '0;
            r_result_valid <= '0;
            r_result       <= '0;
            r_error        <= 1'b0;
            r_cu_request   <= 1'b0;
            r_cu_comp_type <= COMP_ADD;
            r_cu_data      <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= '0;
            r_error        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_id           <= w_pick_id;
                        r_grant        <= w_pick_grant;
                        r_cu_data      <= unit_data[w_pick_id];
                        r_cu_comp_type <= unit_comp_type[w_pick_id];
                        r_cu_request   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    // cu_done is deliberately not looked at here.
                    if (w_timeout) begin
                        r_result       <= '0;
                        r_error        <= 1'b1;
                        r_result_valid <= r_grant;
                        r_cu_request   <= 1'b0;
                        r_state        <= RESP;
                    end else if (r_cu_request && cu_ready) begin
                        r_cu_request <= 1'b0;
                        r_state      <= WAIT;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                WAIT: begin
                    // A real result beats a coincident timeout.
                    if (cu_done) begin
                        r_result       <= cu_result;
                        r_result_valid <= r_grant;
                        r_state        <= RESP;
                    end else if (w_timeout) begin
                        r_result       <= '0;
                        r_error        <= 1'b1;
                        r_result_valid <= r_grant;
                        r_state        <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                RESP: begin
                    r_ptr   <= ID_W'(rr_next(int'(r_id), UNIT_COUNT));
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_grant      <= '0;
                    r_cu_request <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign unit_grant        = r_grant;
    assign unit_result_valid = r_result_valid;
    assign unit_result       = r_result;
    assign unit_error        = r_error;
    assign cu_request        = r_cu_request;
    assign cu_unit_id        = r_id;
    assign cu_comp_type      = r_cu_comp_type;
    assign cu_data           = r_cu_data;
    assign busy              = r_busy;

endmodule

// File: tb/tb_compute_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_compute_request_arbiter
// Scenario tasks drive requesters and a behavioural shared compute unit; the
// expected winner comes from a rotating-priority model kept in the bench.
// -----------------------------------------------------------------------------
module tb_compute_request_arbiter;
    import accel_pkg::*;

    localparam int N   = UNIT_COUNT;
    localparam int IDW = UNIT_ID_WIDTH;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  unit_req;
    comp_type_e    unit_comp_type [N];
    data_t         unit_data      [N];
    logic [N-1:0]  unit_grant;
    logic [N-1:0]  unit_result_valid;
    data_t         unit_result;
    logic          unit_error;
    logic          cu_request;
    logic [IDW-1:0] cu_unit_id;
    comp_type_e    cu_comp_type;
    data_t         cu_data;
    logic          cu_ready;
    logic          cu_done;
    data_t         cu_result;
    logic          busy;

    compute_request_arbiter #(
        .UNIT_COUNT     (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .unit_req          (unit_req),
        .unit_comp_type    (unit_comp_type),
        .unit_data         (unit_data),
        .unit_grant        (unit_grant),
        .unit_result_valid (unit_result_valid),
        .unit_result       (unit_result),
        .unit_error        (unit_error),
        .cu_request        (cu_request),
        .cu_unit_id        (cu_unit_id),
        .cu_comp_type      (cu_comp_type),
        .cu_data           (cu_data),
        .cu_ready          (cu_ready),
        .cu_done           (cu_done),
        .cu_result         (cu_result),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    // observations from one served transaction
    int           o_lat;
    bit           o_started, o_req_held, o_data_stable, o_req_dropped;
    logic [N-1:0] o_grant, o_valid, o_valid_after, o_grant_resp;
    logic [IDW-1:0] o_id;
    data_t        o_data, o_result, o_result_after;
    comp_type_e   o_type;
    logic         o_err, o_busy_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rotating priority: list units starting at ptr, take the first requester.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
        foreach (order[j]) if (req[order[j]]) return order[j];
        return -1;
    endfunction

    // Behavioural shared unit: ready after rd cycles, done dd cycles later.
    task automatic serve(input int rd, input int dd, input data_t res, input bit early_done);
        o_started = 0; o_lat = 0; o_req_held = 1; o_data_stable = 1; o_req_dropped = 1;
        for (int i = 0; i < 20 && !o_started; i++) begin
            step(); o_lat++;
            if (cu_request === 1'b1) o_started = 1;
        end
        if (!o_started) return;
        o_grant = unit_grant; o_id = cu_unit_id; o_data = cu_data; o_type = cu_comp_type;
        for (int i = 0; i < rd; i++) begin
            cu_done   = early_done && (i == rd / 2);
            cu_result = ~res;
            if (early_done) unit_data[o_id] = ~o_data;
            step(); o_lat++;
            cu_done = 1'b0;
            if (cu_request !== 1'b1) o_req_held = 0;
            if (cu_data !== o_data) o_data_stable = 0;
        end
        cu_ready = 1'b1; cu_done = early_done; cu_result = ~res;
        step(); o_lat++;
        cu_ready = 1'b0; cu_done = 1'b0;
        if (cu_request !== 1'b0) o_req_dropped = 0;
        for (int i = 0; i < dd; i++) begin
            step(); o_lat++;
            if (cu_request !== 1'b0) o_req_dropped = 0;
        end
        cu_done = 1'b1; cu_result = res;
        step(); o_lat++;
        cu_done = 1'b0;
        o_valid = unit_result_valid; o_result = unit_result; o_err = unit_error; o_grant_resp = unit_grant;
        step();
        o_valid_after = unit_result_valid; o_busy_after = busy; o_result_after = unit_result;
    endtask

    task automatic test_reset();
        rst = 1'b1; unit_req = '1; cu_ready = 1'b1; cu_done = 1'b1; cu_result = 16'hFFFF;
        step(); step();
        total++; if (busy !== 1'b0 || cu_request !== 1'b0) begin bad++; $display("FAIL reset_busy_req got=%b%b want=00", busy, cu_request); end
        total++; if (unit_grant !== '0 || unit_result_valid !== '0) begin bad++; $display("FAIL reset_grant_valid got=%b/%b want=0/0", unit_grant, unit_result_valid); end
        total++; if (unit_result !== 16'h0000 || cu_data !== 16'h0000 || cu_unit_id !== '0 || unit_error !== 1'b0) begin bad++; $display("FAIL reset_data got=%h/%h/%0d/%b want=0", unit_result, cu_data, cu_unit_id, unit_error); end
        total++; if (cu_comp_type !== COMP_ADD) begin bad++; $display("FAIL reset_comp_type got=%0d want=%0d", cu_comp_type, COMP_ADD); end
        rst = 1'b0; unit_req = '0; cu_ready = 1'b0; cu_done = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b want=0", busy); end
        model_ptr = 0;
    endtask

    task automatic test_contention();
        int exp_order[3] = '{0, 1, 3};
        int want;
        for (int u = 0; u < N; u++) begin
            unit_data[u] = data_t'($urandom); unit_comp_type[u] = comp_type_e'($urandom_range(0, 3));
        end
        unit_req = 4'b1011;
        for (int t = 0; t < 3; t++) begin
            want = model_pick(unit_req, model_ptr);
            serve($urandom_range(0, 2), $urandom_range(0, 2), data_t'($urandom), 1'b0);
            total++; if (!o_started || o_id !== IDW'(exp_order[t]) || want != exp_order[t]) begin bad++; $display("FAIL contention_order[%0d] got=%0d want=%0d", t, o_id, exp_order[t]); end
            total++; if (o_data !== unit_data[exp_order[t]] || o_type !== unit_comp_type[exp_order[t]]) begin bad++; $display("FAIL contention_operand[%0d] got=%h want=%h", t, o_data, unit_data[exp_order[t]]); end
            unit_req[exp_order[t]] = 1'b0;
            model_ptr = (exp_order[t] + 1) % N;
        end
        unit_req = 4'b0101;
        serve(0, 0, 16'h1234, 1'b0);
        total++; if (o_id !== IDW'(0) || o_valid !== 4'b0001) begin bad++; $display("FAIL contention_again got=%0d/%b want=0/0001", o_id, o_valid); end
        unit_req[0] = 1'b0; model_ptr = 1;
        serve(0, 0, 16'h4321, 1'b0);
        unit_req[2] = 1'b0; model_ptr = 3;
    endtask

    task automatic test_single();
        unit_req = 4'b0100; unit_data[2] = 16'h0005; unit_comp_type[2] = COMP_ADD;
        serve(0, 0, 16'h000A, 1'b0);
        total++; if (!o_started || o_lat !== 3) begin bad++; $display("FAIL single_latency got=%0d want=3", o_lat); end
        total++; if (o_grant !== 4'b0100 || o_id !== IDW'(2) || o_grant_resp !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b/%0d want=0100/2", o_grant, o_id); end
        total++; if (o_data !== 16'h0005 || o_type !== COMP_ADD) begin bad++; $display("FAIL single_operand got=%h/%0d want=0005/0", o_data, o_type); end
        total++; if (o_valid !== 4'b0100 || o_result !== 16'h000A || o_err !== 1'b0) begin bad++; $display("FAIL single_result got=%b/%h/%b want=0100/000a/0", o_valid, o_result, o_err); end
        total++; if (o_valid_after !== '0 || o_busy_after !== 1'b0 || o_result_after !== 16'h000A) begin bad++; $display("FAIL single_pulse got=%b/%b/%h want=0/0/000a", o_valid_after, o_busy_after, o_result_after); end
        total++; if (!o_req_dropped) begin bad++; $display("FAIL single_req_drop got=held want=dropped"); end
        unit_req = '0; model_ptr = 3;
    endtask

    task automatic test_wrap();
        unit_req = 4'b0001; unit_data[0] = 16'h00C3;
        serve(1, 1, 16'h0BEE, 1'b0);
        total++; if (o_id !== IDW'(0) || o_grant !== 4'b0001 || o_valid !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%0d/%b want=0/0001", o_id, o_grant); end
        unit_req = 4'b0011;
        serve(0, 0, 16'h0001, 1'b0);
        total++; if (o_id !== IDW'(model_pick(4'b0011, 1))) begin bad++; $display("FAIL wrap_ptr got=%0d want=1", o_id); end
        unit_req = 4'b0001;
        serve(0, 0, 16'h0002, 1'b0);
        unit_req = '0; model_ptr = 1;
    endtask

    task automatic test_backpressure();
        unit_req = 4'b0010; unit_data[1] = 16'h5A5A; unit_comp_type[1] = COMP_MUL;
        serve(5, 1, 16'h7777, 1'b1);
        total++; if (!o_req_held || !o_data_stable) begin bad++; $display("FAIL bp_hold got=%b/%b want=1/1", o_req_held, o_data_stable); end
        total++; if (o_lat !== 3 + 5 + 1 || o_valid !== 4'b0010) begin bad++; $display("FAIL bp_latency got=%0d/%b want=9/0010", o_lat, o_valid); end
        total++; if (o_result !== 16'h7777 || o_type !== COMP_MUL || o_data !== 16'h5A5A) begin bad++; $display("FAIL bp_result got=%h want=7777", o_result); end
        unit_req = '0; model_ptr = 2;
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 0;
        unit_req = 4'b0100; unit_data[2] = 16'h0F0F;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = (cu_request === 1'b1); end
        total++; if (!seen) begin bad++; $display("FAIL rstwait_start got=no_request want=request"); end
        cu_ready = 1'b1; step(); cu_ready = 1'b0;
        step();
        total++; if (busy !== 1'b1 || cu_request !== 1'b0) begin bad++; $display("FAIL rstwait_in_wait got=%b%b want=10", busy, cu_request); end
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (busy !== 1'b0 || cu_request !== 1'b0 || unit_grant !== '0 || unit_result_valid !== '0) begin bad++; $display("FAIL rstwait_outputs got=%b%b/%b/%b want=00/0/0", busy, cu_request, unit_grant, unit_result_valid); end
        total++; if (cu_data !== 16'h0 || cu_unit_id !== '0 || cu_comp_type !== COMP_ADD || unit_result !== 16'h0) begin bad++; $display("FAIL rstwait_regs got=%h/%0d/%0d/%h want=0/0/0/0", cu_data, cu_unit_id, cu_comp_type, unit_result); end
        unit_req = '0; cu_done = 1'b1; cu_result = 16'hDEAD;
        step(); cu_done = 1'b0; step();
        total++; if (unit_result_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rstwait_no_resp got=%b/%b want=0/0", unit_result_valid, busy); end
        model_ptr = 0;
        unit_req = 4'b1010;
        serve(0, 0, 16'h0042, 1'b0);
        total++; if (o_id !== IDW'(model_pick(4'b1010, model_ptr))) begin bad++; $display("FAIL rstwait_ptr got=%0d want=%0d", o_id, model_pick(4'b1010, model_ptr)); end
        unit_req[1] = 1'b0; model_ptr = 2;
        serve(0, 0, 16'h0043, 1'b0);
        unit_req = '0; model_ptr = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend = '0;
        int want, rd, dd, nbad = 0;
        data_t res;
        for (int t = 0; t < 40; t++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 1) == 1) begin
                    pend[u] = 1'b1;
                    unit_data[u] = data_t'($urandom);
                    unit_comp_type[u] = comp_type_e'($urandom_range(0, 3));
                end
            end
            if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
            unit_req = pend;
            want = model_pick(pend, model_ptr);
            rd = $urandom_range(0, 3); dd = $urandom_range(0, 3); res = data_t'($urandom);
            serve(rd, dd, res, 1'b0);
            total++; if (!o_started || o_id !== IDW'(want) || o_grant !== (4'b0001 << want)) begin bad++; nbad++; $display("FAIL rand_winner[%0d] got=%0d want=%0d", t, o_id, want); end
            total++; if (o_data !== unit_data[want] || o_type !== unit_comp_type[want]) begin bad++; nbad++; $display("FAIL rand_operand[%0d] got=%h want=%h", t, o_data, unit_data[want]); end
            total++; if (o_result !== res || o_valid !== (4'b0001 << want) || o_lat !== 3 + rd + dd) begin bad++; nbad++; $display("FAIL rand_result[%0d] got=%h/%b/%0d want=%h/%0d", t, o_result, o_valid, o_lat, res, 3 + rd + dd); end
            pend[want] = 1'b0;
            unit_req = pend;
            model_ptr = (want + 1) % N;
            if (nbad > 6) break;
        end
        while (pend != '0) begin
            want = model_pick(pend, model_ptr);
            serve(0, 0, 16'h0, 1'b0);
            pend[want] = 1'b0; unit_req = pend; model_ptr = (want + 1) % N;
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bit seen = 0;
        unit_req = 4'b0010; cu_ready = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin step(); n++; seen = (unit_result_valid !== '0); end
        total++; if (!seen || n !== TO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TO + 1); end
        total++; if (unit_error !== 1'b1 || unit_result !== 16'h0 || unit_result_valid !== 4'b0010 || cu_request !== 1'b0) begin bad++; $display("FAIL timeout_resp got=%b/%h/%b/%b want=1/0/0010/0", unit_error, unit_result, unit_result_valid, cu_request); end
        unit_req = '0; step();
        cu_done = 1'b1; cu_result = 16'hBAD0; step(); cu_done = 1'b0; step();
        total++; if (unit_result_valid !== '0 || busy !== 1'b0 || unit_error !== 1'b0) begin bad++; $display("FAIL timeout_late_done got=%b/%b/%b want=0/0/0", unit_result_valid, busy, unit_error); end
    endtask
`endif

    initial begin
        rst = 1'b1; unit_req = '0; cu_ready = 1'b0; cu_done = 1'b0; cu_result = '0;
        for (int u = 0; u < N; u++) begin unit_data[u] = '0; unit_comp_type[u] = COMP_ADD; end
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
